// File: rtl/hd_pkg.sv
// Shared types and controller constants for the serial-capture block.
package hd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Shift microstep R + R + CIN: ALU function, mode and carry-in the
    // controller drives while shift_req is high.
    localparam logic [3:0] SHIFT_ALU_S = 4'b1001;
    localparam logic       SHIFT_ALU_M = 1'b0;
    localparam logic       SHIFT_CIN   = 1'b1;

    // Source/destination select for the shift microstep (R3 onto itself).
    localparam logic [3:0] SHIFT_SEL   = 4'b1111;

endpackage

// File: rtl/hd_slot_bank.sv
// DEPTH x WIDTH capture slots: single write port, bulk clear, safe readout.
module hd_slot_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [SLOT_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              clear_all_i,
    input  logic [SLOT_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Slot update: the addressed write beats clear_all; an out-of-range
    // write address matches no slot and is dropped.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_i) begin
                mem_q[i] <= '0;
            end else if (we_i && (waddr_i == SLOT_W'(i))) begin
                mem_q[i] <= wdata_i;
            end else if (clear_all_i) begin
                mem_q[i] <= '0;
            end
        end
    end

    // Readout mux; addresses with no backing slot read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == SLOT_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/hd_serial_capture.sv
// Serial capture sequencer: drives WIDTH shift microsteps, samples the
// carry after each, assembles a word and commits it into one slot.
//
// Handshake: start is a request with no ready; it is taken only in IDLE
// and is dropped (not queued) in any other state. slot and lsb_first are
// latched with the accepted start. done (with stop) is a one-cycle pulse
// in the cycle after the commit edge; start is taken again the cycle after.
module hd_serial_capture
    import hd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic               T3,
    input  logic               CLR,
    input  logic               start,
    input  logic [SLOT_W-1:0]  slot,
    input  logic               lsb_first,
    input  logic               C,
    input  logic               clear_all,
    input  logic [SLOT_W-1:0]  rd_slot,
    output logic               shift_req,
    output logic               stop,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count,
    output logic [WIDTH-1:0]   disp_data,
    output logic [STATE_W-1:0] dbg_state
);

    state_e              state_q;
    logic [CNT_W-1:0]    beat_q;
    logic [CNT_W-1:0]    count_q;
    logic [WIDTH-1:0]    buf_q;
    logic [WIDTH-1:0]    buf_d;
    logic [SLOT_W-1:0]   slot_q;
    logic                lsb_q;
    logic                shift_req_q;
    logic                stop_q;
    logic                busy_q;
    logic                done_q;
    logic                cap_en;
    logic                commit;
    logic [CNT_W-1:0]    bit_idx;

    // Capture path: C lags its shift by one cycle, so beat 0 captures
    // nothing and DRAIN picks up the last bit. The commit writes buf_d so
    // that final bit lands in the slot on the same edge.
    always_comb begin
        cap_en  = ((state_q == ST_SHIFT) && (beat_q != '0)) || (state_q == ST_DRAIN);
        commit  = (state_q == ST_DRAIN);
        bit_idx = lsb_q ? count_q : (CNT_W'(WIDTH - 1) - count_q);
        buf_d   = buf_q;
        if (cap_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (CNT_W'(i) == bit_idx) begin
                    buf_d[i] = C;
                end
            end
        end
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge T3) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            count_q     <= '0;
            buf_q       <= '0;
            slot_q      <= '0;
            lsb_q       <= 1'b0;
            shift_req_q <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            stop_q <= 1'b0;
            buf_q  <= buf_d;
            if (cap_en) begin
                count_q <= count_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_SHIFT;
                        slot_q      <= slot;
                        lsb_q       <= lsb_first;
                        count_q     <= '0;
                        buf_q       <= '0;
                        beat_q      <= '0;
                        shift_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    beat_q <= beat_q + CNT_W'(1);
                    if (beat_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= ST_DRAIN;
                        shift_req_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    stop_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    hd_slot_bank #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SLOT_W (SLOT_W)
    ) u_bank (
        .clk_i       (T3),
        .rst_i       (CLR),
        .we_i        (commit),
        .waddr_i     (slot_q),
        .wdata_i     (buf_d),
        .clear_all_i (clear_all),
        .raddr_i     (rd_slot),
        .rdata_o     (disp_data)
    );

    assign shift_req = shift_req_q;
    assign stop      = stop_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hd_serial_capture.sv
// Directed bench for hd_serial_capture: DEPTH=4 main instance plus a
// DEPTH=3 instance for out-of-range slot behaviour.
module tb_hd_serial_capture;
    import hd_pkg::*;

    // ---------------- clock / reset ----------------
    logic T3 = 1'b0;
    logic CLR;
    always #5 T3 = ~T3;

    // ---------------- DUT A (DEPTH=4) ----------------
    logic       start_a, lsb_a, c_a, clrall_a;
    logic [1:0] slot_a, rd_a;
    logic       shift_a, stop_a, busy_a, done_a;
    logic [3:0] cnt_a;
    logic [7:0] disp_a;
    logic [1:0] st_a;

    hd_serial_capture #(.WIDTH(8), .DEPTH(4)) u_dut_a (
        .T3(T3), .CLR(CLR), .start(start_a), .slot(slot_a), .lsb_first(lsb_a),
        .C(c_a), .clear_all(clrall_a), .rd_slot(rd_a), .shift_req(shift_a),
        .stop(stop_a), .busy(busy_a), .done(done_a), .count(cnt_a),
        .disp_data(disp_a), .dbg_state(st_a)
    );

    // ---------------- DUT B (DEPTH=3) ----------------
    logic       start_b, lsb_b, c_b, clrall_b;
    logic [1:0] slot_b, rd_b;
    logic       shift_b, stop_b, busy_b, done_b;
    logic [3:0] cnt_b;
    logic [7:0] disp_b;
    logic [1:0] st_b;

    hd_serial_capture #(.WIDTH(8), .DEPTH(3)) u_dut_b (
        .T3(T3), .CLR(CLR), .start(start_b), .slot(slot_b), .lsb_first(lsb_b),
        .C(c_b), .clear_all(clrall_b), .rd_slot(rd_b), .shift_req(shift_b),
        .stop(stop_b), .busy(busy_b), .done(done_b), .count(cnt_b),
        .disp_data(disp_b), .dbg_state(st_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // per-cycle trace of one capture, cycles 1..12 after the start edge
    logic       tr_shift [1:12];
    logic       tr_busy  [1:12];
    logic       tr_done  [1:12];
    logic       tr_stop  [1:12];
    logic [3:0] tr_cnt   [1:12];
    logic [7:0] tr_disp  [1:12];
    logic [1:0] tr_state [1:12];

    task automatic step();
        @(posedge T3);
        #1;
    endtask

    // ---------------- driver ----------------
    // Pulses start (edge 0), then feeds cbits[k] as C in cycle k+2 and
    // drives C=1 elsewhere. Optional start / CLR / clear_all pulses in the
    // given cycles (0 = none). Records outputs of each cycle.
    task automatic run_cap(input bit use_b, input logic [1:0] slot, input logic lsb,
                           input logic [7:0] cbits, input int start_at1, input int start_at2,
                           input int clr_at, input int clrall_at, input logic [1:0] rd);
        logic [7:0] sh;
        logic       cval, sval, aval;
        if (!use_b) begin
            slot_a = slot; lsb_a = lsb; start_a = 1'b1; rd_a = rd;
        end else begin
            slot_b = slot; lsb_b = lsb; start_b = 1'b1; rd_b = rd;
        end
        step();
        // scramble the request fields to show they were latched
        if (!use_b) begin
            slot_a = ~slot; lsb_a = ~lsb; start_a = 1'b0;
        end else begin
            slot_b = ~slot; lsb_b = ~lsb; start_b = 1'b0;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            cval = 1'b1;
            if (cyc >= 2 && cyc <= 9) begin
                sh   = cbits >> (cyc - 2);
                cval = sh[0];
            end
            sval = (cyc == start_at1) || (cyc == start_at2);
            aval = (cyc == clrall_at);
            CLR  = (cyc == clr_at);
            if (!use_b) begin
                c_a = cval; start_a = sval; clrall_a = aval;
                tr_shift[cyc] = shift_a; tr_busy[cyc] = busy_a; tr_done[cyc] = done_a;
                tr_stop[cyc] = stop_a; tr_cnt[cyc] = cnt_a; tr_disp[cyc] = disp_a;
                tr_state[cyc] = st_a;
            end else begin
                c_b = cval; start_b = sval; clrall_b = aval;
                tr_shift[cyc] = shift_b; tr_busy[cyc] = busy_b; tr_done[cyc] = done_b;
                tr_stop[cyc] = stop_b; tr_cnt[cyc] = cnt_b; tr_disp[cyc] = disp_b;
                tr_state[cyc] = st_b;
            end
            step();
        end
        CLR = 1'b0;
        c_a = 1'b0; start_a = 1'b0; clrall_a = 1'b0;
        c_b = 1'b0; start_b = 1'b0; clrall_b = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        CLR = 1'b1;
        start_a = 1'b1; c_a = 1'b1; start_b = 1'b1; c_b = 1'b1;
        step();
        step();
        start_a = 1'b0; c_a = 1'b0; start_b = 1'b0; c_b = 1'b0;
        tests_run++;
        if (shift_a !== 1'b0 || stop_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got shift=%b stop=%b busy=%b done=%b required all 0",
                     shift_a, stop_a, busy_a, done_a);
        end
        tests_run++;
        if (cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d required 0", cnt_a);
        end
        tests_run++;
        if (st_a !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d required 0", st_a);
        end
        for (int i = 0; i < 4; i++) begin
            rd_a = 2'(i);
            #1;
            tests_run++;
            if (disp_a !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_slot%0d: got %02h required 00", i, disp_a);
            end
        end
        CLR = 1'b0;
        step();
        tests_run++;
        if (st_a !== 2'd0 || shift_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_hold: got state=%0d shift=%b required 0/0", st_a, shift_a);
        end
    endtask

    task automatic test_msb_first();
        run_cap(1'b0, 2'd0, 1'b0, 8'hA5, 0, 0, 0, 0, 2'd0);
        for (int c = 1; c <= 12; c++) begin
            tests_run++;
            if (tr_shift[c] !== (c <= 8)) begin
                tests_failed++;
                $display("FAIL msb_shift_req_c%0d: got %b required %b", c, tr_shift[c], (c <= 8));
            end
            tests_run++;
            if (tr_busy[c] !== (c <= 9)) begin
                tests_failed++;
                $display("FAIL msb_busy_c%0d: got %b required %b", c, tr_busy[c], (c <= 9));
            end
            tests_run++;
            if (tr_done[c] !== (c == 10) || tr_stop[c] !== (c == 10)) begin
                tests_failed++;
                $display("FAIL msb_done_stop_c%0d: got %b/%b required %b", c, tr_done[c],
                         tr_stop[c], (c == 10));
            end
        end
        tests_run++;
        if (tr_cnt[1] !== 4'd0 || tr_cnt[5] !== 4'd3 || tr_cnt[9] !== 4'd7) begin
            tests_failed++;
            $display("FAIL msb_count_mid: got %0d,%0d,%0d required 0,3,7",
                     tr_cnt[1], tr_cnt[5], tr_cnt[9]);
        end
        tests_run++;
        if (tr_cnt[10] !== 4'd8 || tr_cnt[11] !== 4'd0) begin
            tests_failed++;
            $display("FAIL msb_count_end: got %0d,%0d required 8,0", tr_cnt[10], tr_cnt[11]);
        end
        tests_run++;
        if (tr_state[9] !== 2'd2 || tr_state[10] !== 2'd3 || tr_state[11] !== 2'd0) begin
            tests_failed++;
            $display("FAIL msb_states: got %0d,%0d,%0d required 2,3,0",
                     tr_state[9], tr_state[10], tr_state[11]);
        end
        tests_run++;
        if (tr_disp[9] !== 8'h00) begin
            tests_failed++;
            $display("FAIL msb_pre_commit: got %02h required 00", tr_disp[9]);
        end
        tests_run++;
        if (tr_disp[10] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL msb_word: got %02h required a5", tr_disp[10]);
        end
    endtask

    task automatic test_lsb_first();
        run_cap(1'b0, 2'd2, 1'b1, 8'hA5, 0, 0, 0, 0, 2'd2);
        tests_run++;
        if (tr_disp[10] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL lsb_word_a5: got %02h required a5", tr_disp[10]);
        end
        run_cap(1'b0, 2'd2, 1'b1, 8'h03, 0, 0, 0, 0, 2'd2);
        tests_run++;
        if (tr_disp[9] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL lsb_old_held: got %02h required a5", tr_disp[9]);
        end
        tests_run++;
        if (tr_disp[10] !== 8'h03) begin
            tests_failed++;
            $display("FAIL lsb_word_03: got %02h required 03", tr_disp[10]);
        end
        rd_a = 2'd0;
        #1;
        tests_run++;
        if (disp_a !== 8'hA5) begin
            tests_failed++;
            $display("FAIL lsb_slot0_kept: got %02h required a5", disp_a);
        end
    endtask

    task automatic test_busy_start();
        int n_done;
        run_cap(1'b0, 2'd1, 1'b0, 8'hF0, 4, 9, 0, 0, 2'd1);
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            if (tr_done[c] === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 1 || tr_done[10] !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_done: got %0d pulses (c10=%b) required 1 at c10",
                     n_done, tr_done[10]);
        end
        tests_run++;
        if (tr_shift[11] !== 1'b0 || tr_shift[12] !== 1'b0 ||
            tr_busy[11] !== 1'b0 || tr_busy[12] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_restart: got shift=%b%b busy=%b%b required 00/00",
                     tr_shift[11], tr_shift[12], tr_busy[11], tr_busy[12]);
        end
        tests_run++;
        if (tr_disp[10] !== 8'h0F) begin
            tests_failed++;
            $display("FAIL busy_start_word: got %02h required 0f", tr_disp[10]);
        end
        rd_a = 2'd2;
        #1;
        tests_run++;
        if (disp_a !== 8'h03) begin
            tests_failed++;
            $display("FAIL busy_start_slot2: got %02h required 03", disp_a);
        end
    endtask

    task automatic test_clr_mid();
        int n_done;
        run_cap(1'b0, 2'd1, 1'b1, 8'h3C, 0, 0, 0, 0, 2'd1);
        tests_run++;
        if (tr_disp[10] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL clr_preload: got %02h required 3c", tr_disp[10]);
        end
        run_cap(1'b0, 2'd1, 1'b0, 8'hFF, 0, 0, 5, 0, 2'd1);
        tests_run++;
        if (tr_state[6] !== 2'd0 || tr_cnt[6] !== 4'd0) begin
            tests_failed++;
            $display("FAIL clr_state_count: got %0d/%0d required 0/0", tr_state[6], tr_cnt[6]);
        end
        tests_run++;
        if (tr_shift[6] !== 1'b0 || tr_busy[6] !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_shift_busy: got %b/%b required 0/0", tr_shift[6], tr_busy[6]);
        end
        tests_run++;
        if (tr_disp[6] !== 8'h00 || tr_disp[12] !== 8'h00) begin
            tests_failed++;
            $display("FAIL clr_slot1: got %02h/%02h required 00", tr_disp[6], tr_disp[12]);
        end
        n_done = 0;
        for (int c = 6; c <= 12; c++) begin
            if (tr_done[c] === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL clr_no_done: got %0d pulses required 0", n_done);
        end
    endtask

    task automatic test_clear_all();
        run_cap(1'b0, 2'd0, 1'b0, 8'hFF, 0, 0, 0, 0, 2'd0);
        tests_run++;
        if (tr_disp[10] !== 8'hFF) begin
            tests_failed++;
            $display("FAIL clrall_preload: got %02h required ff", tr_disp[10]);
        end
        run_cap(1'b0, 2'd3, 1'b0, 8'h01, 0, 0, 0, 9, 2'd3);
        tests_run++;
        if (tr_disp[10] !== 8'h80) begin
            tests_failed++;
            $display("FAIL clrall_commit_wins: got %02h required 80", tr_disp[10]);
        end
        rd_a = 2'd0;
        #1;
        tests_run++;
        if (disp_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL clrall_slot0: got %02h required 00", disp_a);
        end
        // clear_all mid-capture must not touch the assembly buffer
        run_cap(1'b0, 2'd2, 1'b1, 8'hA5, 0, 0, 0, 5, 2'd2);
        tests_run++;
        if (tr_disp[10] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL clrall_buffer_kept: got %02h required a5", tr_disp[10]);
        end
        rd_a = 2'd3;
        #1;
        tests_run++;
        if (disp_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL clrall_slot3_cleared: got %02h required 00", disp_a);
        end
    endtask

    task automatic test_depth3();
        int n_done;
        run_cap(1'b1, 2'd1, 1'b1, 8'h96, 0, 0, 0, 0, 2'd1);
        tests_run++;
        if (tr_disp[10] !== 8'h96) begin
            tests_failed++;
            $display("FAIL d3_slot1_word: got %02h required 96", tr_disp[10]);
        end
        rd_b = 2'd3;
        #1;
        tests_run++;
        if (disp_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL d3_rd_oob: got %02h required 00", disp_b);
        end
        run_cap(1'b1, 2'd3, 1'b0, 8'h55, 0, 0, 0, 0, 2'd1);
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            if (tr_done[c] === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 1 || tr_done[10] !== 1'b1) begin
            tests_failed++;
            $display("FAIL d3_oob_done: got %0d pulses (c10=%b) required 1 at c10",
                     n_done, tr_done[10]);
        end
        tests_run++;
        if (tr_disp[10] !== 8'h96 || tr_disp[12] !== 8'h96) begin
            tests_failed++;
            $display("FAIL d3_slot1_kept: got %02h/%02h required 96", tr_disp[10], tr_disp[12]);
        end
        rd_b = 2'd0;
        #1;
        tests_run++;
        if (disp_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL d3_slot0_kept: got %02h required 00", disp_b);
        end
        rd_b = 2'd2;
        #1;
        tests_run++;
        if (disp_b !== 8'h00) begin
            tests_failed++;
            $display("FAIL d3_slot2_kept: got %02h required 00", disp_b);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        CLR = 1'b0;
        start_a = 1'b0; lsb_a = 1'b0; c_a = 1'b0; clrall_a = 1'b0; slot_a = '0; rd_a = '0;
        start_b = 1'b0; lsb_b = 1'b0; c_b = 1'b0; clrall_b = 1'b0; slot_b = '0; rd_b = '0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_busy_start();
        test_clr_mid();
        test_clear_all();
        test_depth3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
